// File: rtl/key_device_if.sv
// Processor load/store bus between the CPU data port and the key device.
// Master drives address/strobes/store data; slave returns load data and hit.
`timescale 1ns/1ps
`default_nettype none

interface key_device_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] dataAddr;
  logic             isLoad;
  logic             isStore;
  logic [DBITS-1:0] wrData;
  logic [DBITS-1:0] rdData;
  logic             rdHit;

  modport master (
    output dataAddr, isLoad, isStore, wrData,
    input  rdData, rdHit
  );

  modport slave (
    input  dataAddr, isLoad, isStore, wrData,
    output rdData, rdHit
  );
endinterface

`default_nettype wire

// File: rtl/key_device.sv
// ============================================================================
// Module   : key_device
// Purpose  : Debounced 4-key input with memory-mapped data/control registers
//            and a level interrupt on Ready & IE.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module key_device #(
  parameter int               DBITS           = 32,
  parameter int               DEBOUNCE_CYCLES = 10,
  parameter logic [DBITS-1:0] KDATA_ADDR      = 32'hF0000010,
  parameter logic [DBITS-1:0] KCTRL_ADDR      = 32'hF0000110
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   KEY,
  key_device_if.slave  bus,
  output logic         irq
);

  localparam int             c_cnt_w = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [3:0]         r_sync1;
  logic [3:0]         r_sync2;
  logic [3:0]         r_key_stable;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_ready;
  logic               r_overrun;
  logic               r_ie;

  logic [3:0]         w_key_sync;
  logic               w_differs;
  logic               w_change;
  logic               w_load;
  logic               w_hit_data;
  logic               w_hit_ctrl;
  logic               w_ctrl_wr;
  logic [DBITS-1:0]   w_kdata;
  logic [DBITS-1:0]   w_kctrl;
  logic               unused_wrdata;

  // Synchronizer idles at all-ones so released keys read as not pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key_sync = ~r_sync2;
  assign w_differs  = (w_key_sync != r_key_stable);
  assign w_change   = w_differs && (r_cnt == c_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_stable <= 4'h0;
      r_cnt        <= '0;
    end else if (!w_differs) begin
      r_cnt        <= '0;
    end else if (w_change) begin
      r_key_stable <= w_key_sync;
      r_cnt        <= '0;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
    end
  end

  // A simultaneous load+store is a store, so it never counts as a read.
  assign w_load     = bus.isLoad && !bus.isStore;
  assign w_hit_data = w_load && (bus.dataAddr == KDATA_ADDR);
  assign w_hit_ctrl = w_load && (bus.dataAddr == KCTRL_ADDR);
  assign w_ctrl_wr  = bus.isStore && (bus.dataAddr == KCTRL_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
      r_ie      <= 1'b0;
    end else begin
      if (w_change) begin
        r_ready <= 1'b1;
      end else if (w_hit_data) begin
        r_ready <= 1'b0;
      end
      // A change consumed by a same-cycle data read is not an overrun.
      if (w_change && r_ready && !w_hit_data) begin
        r_overrun <= 1'b1;
      end else if (w_ctrl_wr && !bus.wrData[2]) begin
        r_overrun <= 1'b0;
      end
      if (w_ctrl_wr) begin
        r_ie <= bus.wrData[8];
      end
    end
  end

  always_comb begin
    w_kdata       = '0;
    w_kdata[3:0]  = r_key_stable;
    w_kctrl       = '0;
    w_kctrl[8]    = r_ie;
    w_kctrl[2]    = r_overrun;
    w_kctrl[0]    = r_ready;
  end

  assign bus.rdHit  = w_hit_data || w_hit_ctrl;
  assign bus.rdData = w_hit_data ? w_kdata :
                      w_hit_ctrl ? w_kctrl : '0;
  assign irq        = r_ready && r_ie;

  assign unused_wrdata = ^{bus.wrData[DBITS-1:9], bus.wrData[7:3], bus.wrData[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_key_device.sv
// Scoreboard bench for key_device: loads push expected data, a negedge
// monitor pops and compares whenever rdHit is presented.
`timescale 1ns/1ps
`default_nettype none

module tb_key_device;

  localparam logic [31:0] KDATA = 32'hF0000010;
  localparam logic [31:0] KCTRL = 32'hF0000110;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key;
  logic       irq;

  always #5 clk = ~clk;

  key_device_if #(.DBITS(32)) bus ();

  key_device #(
    .DBITS          (32),
    .DEBOUNCE_CYCLES(10),
    .KDATA_ADDR     (32'hF0000010),
    .KCTRL_ADDR     (32'hF0000110)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .KEY  (key),
    .bus  (bus),
    .irq  (irq)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rdHit === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rdhit: got rdData %h, expected no hit", bus.rdData);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, bus.rdData, mon_exp);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] e, input string nm);
    bus.dataAddr = a;
    bus.isLoad   = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    bus.isLoad   = 1'b0;
    bus.dataAddr = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.dataAddr = a;
    bus.wrData   = d;
    bus.isStore  = 1'b1;
    tick();
    bus.isStore  = 1'b0;
    bus.dataAddr = '0;
    bus.wrData   = '0;
  endtask

  initial begin
    reset        = 1'b1;
    key          = 4'hF;
    bus.dataAddr = '0;
    bus.isLoad   = 1'b0;
    bus.isStore  = 1'b0;
    bus.wrData   = '0;
    tick(2);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rdhit", {31'd0, bus.rdHit}, 32'd0);
    check("reset_rddata", bus.rdData, 32'd0);
    reset = 1'b0;
    tick(2);
    load(KCTRL, 32'h0, "post_reset_kctrl");
    load(KDATA, 32'h0, "post_reset_kdata");

    // Single press: Ready exactly 12 edges after the KEY edge.
    key = 4'b1110;
    tick(11);
    load(KCTRL, 32'h0, "t1_before_12_edges");
    load(KCTRL, 32'h1, "t1_ready_at_12");
    load(KDATA, 32'h1, "t1_kdata");
    load(KCTRL, 32'h0, "t1_ready_cleared");
    check("t1_irq_ie_off", {31'd0, irq}, 32'd0);

    // Bouncing key never stays changed long enough.
    for (int i = 0; i < 10; i++) begin
      key[1] = ~key[1];
      tick(4);
    end
    tick(14);
    load(KCTRL, 32'h0, "t2_bounce_kctrl");
    load(KDATA, 32'h1, "t2_bounce_kdata");

    // Interrupt enable, overrun on second unread change.
    store(KCTRL, 32'h100);
    load(KCTRL, 32'h100, "t3_ie_set");
    key = 4'b0110;
    tick(12);
    check("t3_irq_high", {31'd0, irq}, 32'd1);
    load(KCTRL, 32'h101, "t3_ready_ie");
    key = 4'b1110;
    tick(12);
    load(KCTRL, 32'h105, "t3_overrun");
    load(KDATA, 32'h1, "t3_kdata");
    load(KCTRL, 32'h104, "t3_overrun_sticky");
    check("t3_irq_low", {31'd0, irq}, 32'd0);
    store(KCTRL, 32'h104);
    load(KCTRL, 32'h104, "t3_ovr_write1_keeps");
    store(KCTRL, 32'h001);
    load(KCTRL, 32'h0, "t3_ovr_cleared_bit0_ignored");

    // Data read coinciding with a change event.
    key = 4'b1010;
    tick(12);
    load(KCTRL, 32'h1, "t4_ready");
    key = 4'b1110;
    tick(11);
    load(KDATA, 32'h5, "t4_kdata_same_cycle");
    load(KCTRL, 32'h1, "t4_ready_kept_no_ovr");
    load(KDATA, 32'h1, "t4_kdata_new");
    load(KCTRL, 32'h0, "t4_cleared");

    // Change event beats a same-cycle Overrun clear.
    key = 4'b1010;
    tick(12);
    key = 4'b1110;
    tick(11);
    store(KCTRL, 32'h0);
    load(KCTRL, 32'h5, "t5_set_beats_clear");
    load(KDATA, 32'h1, "t5_kdata");
    store(KCTRL, 32'h0);
    load(KCTRL, 32'h0, "t5_cleanup");

    // Reset mid-debounce discards the pending change.
    store(KCTRL, 32'h100);
    key = 4'b0110;
    tick(12);
    check("t6_irq_before_reset", {31'd0, irq}, 32'd1);
    key = 4'b1110;
    tick(7);
    reset = 1'b1;
    #1;
    check("t6_irq_in_reset", {31'd0, irq}, 32'd0);
    check("t6_rdhit_in_reset", {31'd0, bus.rdHit}, 32'd0);
    tick(2);
    check("t6_irq_in_reset_late", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    tick(11);
    load(KCTRL, 32'h0, "t6_before_full_debounce");
    load(KCTRL, 32'h1, "t6_redebounced");
    load(KDATA, 32'h1, "t6_kdata");
    check("t6_irq_ie_reset", {31'd0, irq}, 32'd0);

    // Address decode and load+store collision.
    key = 4'b1010;
    tick(12);
    bus.dataAddr = 32'hF0000014;
    bus.isLoad   = 1'b1;
    #2;
    check("t7_miss_rdhit", {31'd0, bus.rdHit}, 32'd0);
    check("t7_miss_rddata", bus.rdData, 32'd0);
    tick();
    bus.dataAddr = KDATA;
    bus.isStore  = 1'b1;
    #2;
    check("t7_both_rdhit", {31'd0, bus.rdHit}, 32'd0);
    check("t7_both_rddata", bus.rdData, 32'd0);
    tick();
    bus.isLoad   = 1'b0;
    bus.isStore  = 1'b0;
    bus.dataAddr = '0;
    load(KCTRL, 32'h1, "t7_ready_unchanged");
    store(KDATA, 32'hF);
    load(KDATA, 32'h5, "t7_kdata_read_only");
    load(KCTRL, 32'h0, "t7_ready_cleared");

    tick(2);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_device.md
KEY_DEVICE -- requirements
Module: key_device

Interface
REQ-001 Parameter DBITS, 32, width of the data bus and address.
REQ-002 Parameter DEBOUNCE_CYCLES, 10, number of consecutive stable cycles required before a key change is accepted; legal range is at least 2.
REQ-003 Parameter KDATA_ADDR, 32'hF0000010, byte address of the key data register.
REQ-004 Parameter KCTRL_ADDR, 32'hF0000110, byte address of the key control/status register.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 KEY  input  4  raw board keys, active-low (0 = pressed), asynchronous to clk.
REQ-008 dataAddr  input  DBITS  processor load/store address.
REQ-009 isLoad  input  1  processor load in progress this cycle.
REQ-010 isStore  input  1  processor store in progress this cycle.
REQ-011 wrData  input  DBITS  store data.
REQ-012 rdData  output  DBITS  load data; combinational from registers.
REQ-013 rdHit  output  1  high when isLoad is high and dataAddr equals KDATA_ADDR or KCTRL_ADDR; processor selects rdData on this.
REQ-014 irq  output  1  interrupt request = KCTRL.Ready AND KCTRL.IE, registered-state derived.

Function
REQ-015 KEY SHALL pass through a 2-flop synchronizer; the synchronized value is inverted to active-high keySync[3:0].
REQ-016 A counter SHALL run while keySync != keyStable; it SHALL clear to 0 in any cycle keySync == keyStable, including when keySync changes back to a prior value mid-count.
REQ-017 When the counter equals DEBOUNCE_CYCLES-1 and keySync still != keyStable, keyStable SHALL load keySync, the counter SHALL clear, and a one-cycle change event SHALL fire.
REQ-018 Latency: a clean KEY edge SHALL reach keyStable exactly 2 + DEBOUNCE_CYCLES rising edges later.
REQ-019 KDATA read value SHALL be {28'd0, keyStable}; stores to KDATA SHALL be ignored.
REQ-020 KCTRL read value SHALL be {23'd0, IE at bit 8, 5'd0, Overrun at bit 2, 1'b0, Ready at bit 0}.
REQ-021 A change event SHALL set Ready; if Ready is already 1, it SHALL also set Overrun.
REQ-022 A load from KDATA SHALL clear Ready at the next edge; if a change event occurs in the same cycle, Ready SHALL stay 1 and Overrun SHALL NOT be set.
REQ-023 A store to KCTRL SHALL write IE from wrData[8]; wrData[2]=0 SHALL clear Overrun, and writing 1 SHALL leave it unchanged; wrData[0] SHALL be ignored.
REQ-024 When a change event and a KCTRL store that clears Overrun occur in the same cycle, setting SHALL take priority over clearing.
REQ-025 rdData SHALL be 0 when rdHit is 0; isLoad and isStore asserted together SHALL be treated as a store only, with rdHit = 0.
REQ-026 Address compare SHALL use the full DBITS address; any other address SHALL have no effect.

Reset
REQ-027 On reset assertion, the synchronizer flops SHALL go to 1 (released), keyStable to 0, counter to 0, and Ready/Overrun/IE to 0; rdHit, rdData and irq SHALL be 0 while no load is pending.
REQ-028 Reset in mid-debounce SHALL discard the pending change; after release, a key still held SHALL be re-debounced from count 0.

Verification
REQ-029 Reset, then hold KEY=4'b1110 -> keyStable=4'h1 and Ready=1 exactly 12 edges later (DEBOUNCE_CYCLES=10); load KDATA -> rdData=32'h1, then Ready=0.
REQ-030 Toggle KEY[1] every 4 cycles for 40 cycles -> no change event, KCTRL reads 32'h0.
REQ-031 Store 32'h100 to KCTRL, press KEY[3] -> irq=1 after debounce; a second change before any KDATA read -> KCTRL reads 32'h105.
REQ-032 KDATA load in the same cycle as a change event -> Ready remains 1, Overrun remains 0.
REQ-033 Assert reset at count 5 with KEY held -> after release, keyStable changes only after a full 2+10 edges; irq=0 throughout reset.
REQ-034 Load from 32'hF0000014 -> rdHit=0, rdData=0; isLoad and isStore both high on KDATA_ADDR -> rdHit=0 and Ready unchanged.
